// File: rtl/dispatch_unit_pkg.sv
// Shared issue-side definitions: Q-tag encoding, internal opcodes and operand resolution.
// Also used by the reservation station and the ROB.
package dispatch_unit_pkg;

    localparam int RoB_WIDTH = 3;
    localparam int Q_WIDTH   = RoB_WIDTH + 1;

    typedef logic [Q_WIDTH-1:0] q_tag_t;

    localparam q_tag_t NON_DEP = {1'b1, {RoB_WIDTH{1'b0}}};

    localparam logic [6:0] OP_ADD  = 7'd1;
    localparam logic [6:0] OP_SUB  = 7'd2;
    localparam logic [6:0] OP_ADDI = 7'd3;
    localparam logic [6:0] OP_BEQ  = 7'd4;
    localparam logic [6:0] OP_BNE  = 7'd5;
    localparam logic [6:0] OP_JALR = 7'd6;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } disp_state_e;

    typedef struct packed {
        logic [31:0] v;
        q_tag_t      q;
    } operand_t;

    function automatic logic tag_match(input q_tag_t q, input logic [RoB_WIDTH-1:0] idx);
        return q == {1'b0, idx};
    endfunction

    // First matching source wins: unused/x0, register file, CDB, ROB, else wait on tag.
    function automatic operand_t resolve_operand(
        input logic                 use_s,
        input logic [4:0]           rs,
        input q_tag_t               q,
        input logic [31:0]          rf_data,
        input logic                 cdb_en,
        input logic [RoB_WIDTH-1:0] cdb_idx,
        input logic [31:0]          cdb_data,
        input logic                 rob_ready,
        input logic [31:0]          rob_data
    );
        operand_t r;
        r.v = 32'd0;
        r.q = NON_DEP;
        if (!use_s || (rs == 5'd0)) begin
            r.v = 32'd0;
            r.q = NON_DEP;
        end else if (q == NON_DEP) begin
            r.v = rf_data;
        end else if (cdb_en && tag_match(q, cdb_idx)) begin
            r.v = cdb_data;
        end else if (rob_ready) begin
            r.v = rob_data;
        end else begin
            r.v = 32'd0;
            r.q = q;
        end
        return r;
    endfunction

endpackage

// File: rtl/dispatch_unit_reg_status_table.sv
// Register status (rename) table: maps each architectural register to its producing ROB tag.
// Two read ports, one dispatch write, one conditional commit clear, global flush.
module reg_status_table
    import dispatch_unit_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic [4:0]           rd_idx1,
    input  logic [4:0]           rd_idx2,
    output q_tag_t               rd_q1,
    output q_tag_t               rd_q2,
    input  logic                 wr_en,
    input  logic [4:0]           wr_idx,
    input  logic [RoB_WIDTH-1:0] wr_tag,
    input  logic                 clr_en,
    input  logic [4:0]           clr_idx,
    input  logic [RoB_WIDTH-1:0] clr_tag
);

    q_tag_t qi_q [32];
    q_tag_t qi_d [32];

    assign rd_q1 = (rd_idx1 == 5'd0) ? NON_DEP : qi_q[rd_idx1];
    assign rd_q2 = (rd_idx2 == 5'd0) ? NON_DEP : qi_q[rd_idx2];

    // Next table contents; the dispatch write is applied after the commit clear so it wins.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            qi_d[i] = qi_q[i];
        end
        if (flush_in) begin
            for (int i = 0; i < 32; i++) begin
                qi_d[i] = NON_DEP;
            end
        end else if (rdy_in) begin
            if (clr_en && tag_match(qi_q[clr_idx], clr_tag)) begin
                qi_d[clr_idx] = NON_DEP;
            end else begin
                qi_d[clr_idx] = qi_d[clr_idx];
            end
            if (wr_en && (wr_idx != 5'd0)) begin
                qi_d[wr_idx] = {1'b0, wr_tag};
            end else begin
                qi_d[wr_idx] = qi_d[wr_idx];
            end
        end else begin
            qi_d[0] = NON_DEP;
        end
        qi_d[0] = NON_DEP;
    end

    // Table storage.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 32; i++) begin
                qi_q[i] <= NON_DEP;
            end
        end else begin
            qi_q <= qi_d;
        end
    end

endmodule

// File: rtl/dispatch_unit.sv
// Dispatch unit: accepts one decoded instruction, resolves operands, allocates a ROB tag
// and presents a complete reservation-station entry one cycle later.
module dispatch_unit
    import dispatch_unit_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 inst_valid,
    output logic                 inst_ready,
    input  logic [6:0]           inst_opcode,
    input  logic [31:0]          inst_imm,
    input  logic [31:0]          inst_pc,
    input  logic [4:0]           inst_rd,
    input  logic [4:0]           inst_rs1,
    input  logic [4:0]           inst_rs2,
    input  logic                 inst_has_rd,
    input  logic                 inst_use_rs1,
    input  logic                 inst_use_rs2,
    output logic [4:0]           rf_rs1,
    output logic [4:0]           rf_rs2,
    input  logic [31:0]          rf_rs1_data,
    input  logic [31:0]          rf_rs2_data,
    output logic [RoB_WIDTH-1:0] rob_q1_index,
    output logic [RoB_WIDTH-1:0] rob_q2_index,
    input  logic                 rob_q1_ready,
    input  logic                 rob_q2_ready,
    input  logic [31:0]          rob_q1_data,
    input  logic [31:0]          rob_q2_data,
    input  logic                 rob_full,
    input  logic [RoB_WIDTH-1:0] rob_tail,
    output logic                 rob_alloc_en,
    output logic [4:0]           rob_alloc_rd,
    input  logic                 rs_full,
    output logic                 new_entry_en,
    output logic [RoB_WIDTH-1:0] new_entry_robEntry,
    output logic [6:0]           new_entry_opcode,
    output logic [31:0]          new_entry_Vj,
    output logic [31:0]          new_entry_Vk,
    output logic [RoB_WIDTH:0]   new_entry_Qj,
    output logic [RoB_WIDTH:0]   new_entry_Qk,
    output logic [31:0]          new_entry_imm,
    output logic [31:0]          new_entry_pc,
    input  logic                 CDB_update_en,
    input  logic [RoB_WIDTH-1:0] CDB_update_index,
    input  logic [31:0]          CDB_update_data,
    input  logic                 commit_en,
    input  logic [4:0]           commit_rd,
    input  logic [RoB_WIDTH-1:0] commit_robEntry,
    input  logic                 flush_signal
);

    disp_state_e          state_q, state_d;
    logic                 entry_en_q, entry_en_d;
    logic [6:0]           hold_opcode_q, hold_opcode_d;
    logic [31:0]          hold_imm_q, hold_imm_d;
    logic [31:0]          hold_pc_q, hold_pc_d;
    logic [RoB_WIDTH-1:0] hold_tag_q, hold_tag_d;
    logic [4:0]           hold_rd_q, hold_rd_d;
    logic [31:0]          hold_vj_q, hold_vj_d;
    logic [31:0]          hold_vk_q, hold_vk_d;
    q_tag_t               hold_qj_q, hold_qj_d;
    q_tag_t               hold_qk_q, hold_qk_d;

    q_tag_t   rs1_q_s, rs2_q_s;
    operand_t op1_s, op2_s;
    logic     transfer_s;

    assign inst_ready = (state_q == ST_IDLE) && rdy_in && !flush_signal && !rs_full && !rob_full;
    assign transfer_s = inst_valid && inst_ready;

    assign rf_rs1       = inst_rs1;
    assign rf_rs2       = inst_rs2;
    assign rob_q1_index = rs1_q_s[RoB_WIDTH-1:0];
    assign rob_q2_index = rs2_q_s[RoB_WIDTH-1:0];

    reg_status_table u_rst (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .rdy_in  (rdy_in),
        .flush_in(flush_signal),
        .rd_idx1 (inst_rs1),
        .rd_idx2 (inst_rs2),
        .rd_q1   (rs1_q_s),
        .rd_q2   (rs2_q_s),
        .wr_en   (transfer_s && inst_has_rd),
        .wr_idx  (inst_rd),
        .wr_tag  (rob_tail),
        .clr_en  (commit_en),
        .clr_idx (commit_rd),
        .clr_tag (commit_robEntry)
    );

    // Operand resolution in the accept cycle; the table still holds the old tag for rs==rd.
    always_comb begin
        op1_s = resolve_operand(inst_use_rs1, inst_rs1, rs1_q_s, rf_rs1_data, CDB_update_en,
                                CDB_update_index, CDB_update_data, rob_q1_ready, rob_q1_data);
        op2_s = resolve_operand(inst_use_rs2, inst_rs2, rs2_q_s, rf_rs2_data, CDB_update_en,
                                CDB_update_index, CDB_update_data, rob_q2_ready, rob_q2_data);
    end

    // FSM next state and hold-register capture.
    always_comb begin
        state_d       = state_q;
        entry_en_d    = entry_en_q;
        hold_opcode_d = hold_opcode_q;
        hold_imm_d    = hold_imm_q;
        hold_pc_d     = hold_pc_q;
        hold_tag_d    = hold_tag_q;
        hold_rd_d     = hold_rd_q;
        hold_vj_d     = hold_vj_q;
        hold_vk_d     = hold_vk_q;
        hold_qj_d     = hold_qj_q;
        hold_qk_d     = hold_qk_q;
        if (flush_signal) begin
            state_d    = ST_IDLE;
            entry_en_d = 1'b0;
        end else if (!rdy_in) begin
            state_d    = state_q;
            entry_en_d = entry_en_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (transfer_s) begin
                        state_d       = ST_ISSUE;
                        entry_en_d    = 1'b1;
                        hold_opcode_d = inst_opcode;
                        hold_imm_d    = inst_imm;
                        hold_pc_d     = inst_pc;
                        hold_tag_d    = rob_tail;
                        hold_rd_d     = inst_rd;
                        hold_vj_d     = op1_s.v;
                        hold_vk_d     = op2_s.v;
                        hold_qj_d     = op1_s.q;
                        hold_qk_d     = op2_s.q;
                    end else begin
                        entry_en_d = 1'b0;
                    end
                end
                ST_ISSUE: begin
                    state_d    = ST_IDLE;
                    entry_en_d = 1'b0;
                end
                default: begin
                    state_d    = ST_IDLE;
                    entry_en_d = 1'b0;
                end
            endcase
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            entry_en_q    <= 1'b0;
            hold_opcode_q <= 7'd0;
            hold_imm_q    <= 32'd0;
            hold_pc_q     <= 32'd0;
            hold_tag_q    <= {RoB_WIDTH{1'b0}};
            hold_rd_q     <= 5'd0;
            hold_vj_q     <= 32'd0;
            hold_vk_q     <= 32'd0;
            hold_qj_q     <= NON_DEP;
            hold_qk_q     <= NON_DEP;
        end else begin
            state_q       <= state_d;
            entry_en_q    <= entry_en_d;
            hold_opcode_q <= hold_opcode_d;
            hold_imm_q    <= hold_imm_d;
            hold_pc_q     <= hold_pc_d;
            hold_tag_q    <= hold_tag_d;
            hold_rd_q     <= hold_rd_d;
            hold_vj_q     <= hold_vj_d;
            hold_vk_q     <= hold_vk_d;
            hold_qj_q     <= hold_qj_d;
            hold_qk_q     <= hold_qk_d;
        end
    end

    // The RS ignores the CDB for the entry it is latching, so forward a same-cycle broadcast here.
    always_comb begin
        new_entry_Vj = hold_vj_q;
        new_entry_Qj = hold_qj_q;
        new_entry_Vk = hold_vk_q;
        new_entry_Qk = hold_qk_q;
        if ((state_q == ST_ISSUE) && CDB_update_en && tag_match(hold_qj_q, CDB_update_index)) begin
            new_entry_Vj = CDB_update_data;
            new_entry_Qj = NON_DEP;
        end else begin
            new_entry_Vj = hold_vj_q;
        end
        if ((state_q == ST_ISSUE) && CDB_update_en && tag_match(hold_qk_q, CDB_update_index)) begin
            new_entry_Vk = CDB_update_data;
            new_entry_Qk = NON_DEP;
        end else begin
            new_entry_Vk = hold_vk_q;
        end
    end

    assign new_entry_en       = entry_en_q;
    assign rob_alloc_en       = entry_en_q;
    assign rob_alloc_rd       = hold_rd_q;
    assign new_entry_robEntry = hold_tag_q;
    assign new_entry_opcode   = hold_opcode_q;
    assign new_entry_imm      = hold_imm_q;
    assign new_entry_pc       = hold_pc_q;

endmodule

// File: doc/dispatch_unit.md
# dispatch_unit

Issue-side initiator of the reservation-station entry interface. It accepts one decoded ALU/branch/jalr instruction from the decoder and resolves both source operands from the architectural register file, the ROB and the CDB. It then allocates a ROB tag and presents a complete entry (`new_entry_*`) to the reservation station, while maintaining the register status (rename) table that maps each architectural register to its producing ROB tag.

## Interface
- `RoB_WIDTH`, 3: ROB index width.
- `NON_DEP`, `1 << RoB_WIDTH`: Q encoding meaning "value present".
- `clk_in` in 1: clock.
- `rst_in` in 1: reset, asynchronous and active-high.
- `rdy_in` in 1: global enable; low means freeze.
- `inst_valid` in 1 / `inst_ready` out 1: decoder handshake; transfer occurs when both are high at a rising edge.
- `inst_opcode` in 7 / `inst_imm` in 32 / `inst_pc` in 32: internal opcode, immediate and PC.
- `inst_rd`, `inst_rs1`, `inst_rs2` in 5 each / `inst_has_rd`, `inst_use_rs1`, `inst_use_rs2` in 1 each: register fields and their use flags.
- `rf_rs1`, `rf_rs2` out 5 / `rf_rs1_data`, `rf_rs2_data` in 32: combinational register-file read.
- `rob_q1_index`, `rob_q2_index` out RoB_WIDTH / `rob_q1_ready`, `rob_q2_ready` in 1 / `rob_q1_data`, `rob_q2_data` in 32: combinational ROB value query.
- `rob_full` in 1 / `rob_tail` in RoB_WIDTH: ROB status and next free tag.
- `rob_alloc_en` out 1 / `rob_alloc_rd` out 5: ROB allocation pulse and destination register.
- `rs_full` in 1: reservation station full.
- `new_entry_en` out 1, `new_entry_robEntry` out RoB_WIDTH, `new_entry_opcode` out 7: entry valid, tag and opcode.
- `new_entry_Vj`, `new_entry_Vk` out 32 / `new_entry_Qj`, `new_entry_Qk` out RoB_WIDTH+1: operand values and tags.
- `new_entry_imm`, `new_entry_pc` out 32: immediate and PC.
- `CDB_update_en` in 1 / `CDB_update_index` in RoB_WIDTH / `CDB_update_data` in 32: result broadcast.
- `commit_en` in 1 / `commit_rd` in 5 / `commit_robEntry` in RoB_WIDTH: ROB commit.
- `flush_signal` in 1: misprediction flush.

## Operation
- FSM with two states, IDLE and ISSUE.
  - `inst_ready = (state==IDLE) && rdy_in && !flush_signal && !rs_full && !rob_full`.
  - A transfer moves IDLE→ISSUE. ISSUE always returns to IDLE after one cycle.
  - Throughput is therefore at most one entry per 2 cycles. This absorbs the one-cycle lag of `rs_full` and `rob_tail`.
- Operand resolution is combinational in the accept cycle, evaluated per source s with q = Qi[rs_s]. First matching rule wins:
  - `!use_s` or `rs_s==0`: V=0, Q=NON_DEP.
  - q==NON_DEP: V=rf data, Q=NON_DEP.
  - CDB_update_en and index==q: V=CDB data, Q=NON_DEP.
  - rob_q_s_ready: V=rob data, Q=NON_DEP.
  - Otherwise: V=0, Q=q.
  - `rob_q_s_index = q[RoB_WIDTH-1:0]`.
- On transfer, the resolved operands, opcode, imm, pc, tag (`rob_tail`) and rd are latched into hold registers.
- `new_entry_en` and `rob_alloc_en` are registered and high exactly during ISSUE.
- CDB patch in ISSUE: the RS ignores the CDB for the entry it is latching, so the dispatcher patches the outputs combinationally.
  - If `CDB_update_en` and hold Qj==`CDB_update_index`: `new_entry_Qj`=NON_DEP and `new_entry_Vj`=CDB data.
  - The same rule applies independently to Qk.
- Rename table (32 × RoB_WIDTH+1 bits):
  - On transfer with has_rd and rd≠0: Qi[rd]←rob_tail.
  - On commit_en with Qi[commit_rd]==commit_robEntry: Qi[commit_rd]←NON_DEP.
  - When both target the same rd in one cycle, the dispatch write wins.
  - x0 always reads NON_DEP.
- Flush (takes priority over everything except reset): all Qi←NON_DEP, state←IDLE, `new_entry_en`/`rob_alloc_en`←0, no transfer that cycle. An entry in ISSUE is dropped.
- `rdy_in` low: all state is held, `inst_ready`=0, registered outputs are held.

## Timing
- Reset values: state IDLE; `new_entry_en`=0, `rob_alloc_en`=0; all hold Q = NON_DEP; all other hold registers and data outputs 0; all Qi = NON_DEP.
- Latency: transfer at edge N; `new_entry_en`=1 in cycle N+1; the RS latches the entry at edge N+2.
- `inst_ready` is combinational from state and inputs. It is never high in ISSUE.
- An instruction whose rs equals its own rd reads the old Qi, not the new tag.
- A CDB broadcast in the accept cycle is captured by resolution. A broadcast in the ISSUE cycle is captured by the patch. No wakeup is lost.
- Reset asserted mid-ISSUE clears immediately (asynchronous); no pulse completes.

## Structure
- Shared package holds NON_DEP, the internal opcode constants and the Q-width typedef. These are shared with the reservation station and ROB.
- Sub-module `reg_status_table`: 32-entry Qi array with two combinational read ports, one dispatch write port, one conditional commit clear and flush.

## Test plan
- **Independent:** reset, then addi x1,x0,5 at pc=0x100 with rob_tail=2.
  - Cycle N+1: new_entry_en=1, robEntry=2, Qj=8, Vj=0, imm=5.
  - Qi[1]=2 afterwards.
- **RAW on pending tag:** add x2,x1,x1 issued right after, with ROB tag 2 not ready.
  - Qj=Qk=2.
  - If the CDB broadcasts index 2 data 0x7 during ISSUE, the outputs show Qj=Qk=8 and Vj=Vk=7.
- **ROB bypass:** rob_q1_ready=1 with data 0xABCD for a pending tag → Qj=8, Vj=0xABCD.
- **Back-pressure:** rs_full=1 → inst_ready=0, no pulse. Release → accepted. A second instruction held valid is accepted no earlier than 2 cycles later.
- **Commit vs dispatch:** commit rd=3, tag 4 in the same cycle as a dispatch writing x3 with tag 5 → Qi[3]=5.
  - A commit with a non-matching tag leaves Qi unchanged.
- **Flush:** flush_signal during ISSUE → new_entry_en=0 the next cycle and all Qi=NON_DEP. A subsequent read of x1 takes its value from rf data.
